input_arbiter_nport: RTL and testbench
======================================

Name: input_arbiter_nport

Overview:
- Parametrised N-port AXI-Stream input arbiter for the TSN switch datapath. It sits between the per-port RX queues and the output-port lookup stage.
- Each slave port feeds a fall-through FIFO. One packet at a time is forwarded atomically to a single master stream.
- Arbitration mode is selectable at runtime: work-conserving round-robin, or strict priority (lower port index wins).
- Adds a per-port enable mask and zero-bubble grant: no idle cycles are spent scanning empty queues.

Parameters:
- NUM_PORTS, 6: number of slave ports, 2..16.
- C_M_AXIS_DATA_WIDTH, 256: master tdata width; tkeep is width/8.
- C_S_AXIS_DATA_WIDTH, 256: slave tdata width; must equal the master width.
- C_M_AXIS_TUSER_WIDTH, 128: master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128: slave tuser width; must equal the master width.
- MAX_PKT_BYTES, 2000: sizes each FIFO. FIFO_DEPTH_BITS = clog2(MAX_PKT_BYTES/(DATA_WIDTH/8)).

Ports:
- axis_aclk  in  1  sole clock.
- axis_resetn  in  1  synchronous, active-low reset.
- s_axis_tdata  in  NUM_PORTS*DATA_WIDTH  port p occupies slice [p*W +: W].
- s_axis_tkeep  in  NUM_PORTS*DATA_WIDTH/8  packed per port.
- s_axis_tuser  in  NUM_PORTS*TUSER_WIDTH  packed per port.
- s_axis_tvalid  in  NUM_PORTS  one bit per port.
- s_axis_tready  out  NUM_PORTS  per-port ready; equals ~nearly_full[p].
- s_axis_tlast  in  NUM_PORTS  one bit per port.
- m_axis_tdata  out  DATA_WIDTH  master data.
- m_axis_tkeep  out  DATA_WIDTH/8  master byte enables.
- m_axis_tuser  out  TUSER_WIDTH  master sideband.
- m_axis_tvalid  out  1  master valid.
- m_axis_tready  in  1  master ready.
- m_axis_tlast  out  1  master end of packet.
- arb_mode  in  1  0 = round-robin, 1 = strict priority.
- port_enable  in  NUM_PORTS  1 = port eligible for a new grant.
- cur_port  out  clog2(NUM_PORTS)  port currently granted (registered).
- pkt_fwd  out  1  one-cycle pulse on each packet's first-beat handshake.
- pkt_fwd_port  out  NUM_PORTS  one-hot copy of pkt_fwd, identifying the source port.

Behaviour:
- Ingress
  - FIFO p is written when s_axis_tvalid[p] & s_axis_tready[p].
  - FIFO word layout is {tlast, tuser, tkeep, tdata}.
  - A FIFO never overflows; s_axis_tready drops when nearly_full asserts.
- Eligibility: elig = ~empty & port_enable.
- Grant, combinational, evaluated only in IDLE:
  - RR: first eligible port scanning from last_grant+1, wrapping NUM_PORTS-1 -> 0.
  - SP: lowest-index eligible port.
  - none eligible: no grant; m_axis_tvalid = 0.
- State machine (IDLE, WR_PKT), registered state, last_grant and cur_port.
  - IDLE: sel = grant; m_axis_tvalid = |elig.
    - On handshake (tvalid & tready): pop FIFO[sel], cur_port <= sel, pulse pkt_fwd.
    - If that beat has tlast=0: go to WR_PKT.
    - If that beat has tlast=1 (single-beat packet): stay IDLE and set last_grant <= sel.
  - WR_PKT: sel = cur_port; m_axis_tvalid = ~empty[cur_port].
    - Pop only on handshake.
    - Handshake with tlast=1: go to IDLE, last_grant <= cur_port.
    - A FIFO underrun mid-packet stalls the output (tvalid low); it never ends the packet.
- Master data outputs are the FIFO[sel] head fields, with zero added latency (fall-through).
- Packet atomicity:
  - No grant change inside a packet.
  - Changes to port_enable or arb_mode mid-packet take effect only at the next IDLE arbitration.
- Back-to-back packets: the next packet's first beat may be presented in the cycle after tlast. No bubble is required beyond that one IDLE cycle.
- AXI rule: once tvalid is high, the output data must hold stable until ready, within a packet. In IDLE, grant may change while tready is low. This is allowed because no beat has been accepted yet.
- Reset (also mid-packet):
  - state = IDLE, last_grant = NUM_PORTS-1 (so port 0 is considered first), cur_port = 0, pkt_fwd = 0, pkt_fwd_port = 0.
  - FIFOs are flushed, so m_axis_tvalid = 0 and s_axis_tready = all ones from the cycle after reset is sampled low.
  - Any partial packet is discarded.
- Width rule: cur_port and last_grant are clog2(NUM_PORTS) bits wide. Wrap uses an explicit compare against NUM_PORTS-1, never natural overflow.

Decomposition:
- Shared package (axis_arb_pkg):
  - ARB_RR/ARB_SP mode constants.
  - IDLE/WR_PKT state encoding.
  - clog2 function.
- Sub-module: the existing fallthrough_small_fifo, one instance per port via generate.
- The grant logic becomes a separate sub-module rr_sp_grant (inputs: elig, last_grant, mode; output: grant index plus a valid bit). This lets it be unit-tested in isolation.

Test Plan:
- RR fairness: NUM_PORTS=6, RR, ports 0,2,5 each hold three 4-beat packets, tready=1 -> grant order 0,2,5 repeated three times; no packet interleaving; 9 pkt_fwd pulses; one IDLE cycle between packets.
- Strict priority: SP, port 4 holds a 10-beat packet mid-transfer when port 1 fills -> port 4 completes all 10 beats, then port 1 is granted before port 4's next queued packet.
- Enable mask: port_enable=6'b111110 with port 0 non-empty -> port 0 is never granted. Set bit 0 -> port 0 is granted at the next IDLE.
- Backpressure/underrun: random tready at 50%, with port 3 writer pausing mid-packet -> output beats are bit-exact to input, tlast aligned, tvalid low during underrun, no dropped or duplicated beats.
- Single-beat packets: ports 0 and 1 each hold five 1-beat packets under RR -> output alternates 0,1; cur_port tracks the source; pkt_fwd_port is one-hot matching the source.
- Reset mid-packet: assert axis_resetn=0 on beat 3 of 8 from port 2 -> next cycle tvalid=0, pkt_fwd=0, cur_port=0; after release a new packet on port 2 is forwarded intact; no remnant beats appear.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared definitions for the N-port AXI-Stream input arbiter.
//   ARB_RR / ARB_SP : values of the runtime arb_mode input.
//   arb_state_e     : arbiter FSM encoding (IDLE, WR_PKT).
//   clog2()         : ceiling log2, never less than 1, for index widths.
package axis_arb_pkg;

    localparam logic ARB_RR = 1'b0;
    localparam logic ARB_SP = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Fall-through FIFO: the head word is visible on dout_o while empty_o is low,
// with no read latency. rd_en_i pops the head.
//   clk_i, rst_ni      : clock, synchronous active-low flush
//   din_i, wr_en_i     : write port (writes ignored when completely full)
//   dout_o, rd_en_i    : head word and pop (pops ignored when empty)
//   empty_o            : no words stored
//   nearly_full_o      : at most one free slot left
module fallthrough_small_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             nearly_full_o
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0]   NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q;
    logic [DEPTH_BITS-1:0] rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  do_wr;
    logic                  do_rd;

    assign do_wr = wr_en_i && (count_q != CNT_FULL);
    assign do_rd = rd_en_i && !empty_o;

    // Storage has no reset; flushing only clears the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Asynchronous head read gives the zero-latency fall-through view.
    assign dout_o        = mem_q[rd_ptr_q];
    assign empty_o       = (count_q == '0);
    assign nearly_full_o = (count_q >= NF_LEVEL);

endmodule

// File: rtl/rr_sp_grant.sv
// Combinational grant selection.
//   elig_i        : per-port eligibility (non-empty and enabled)
//   last_grant_i  : port that finished the previous packet
//   mode_i        : ARB_RR = round-robin after last_grant_i, ARB_SP = lowest index
//   grant_o       : selected port index (meaningful only with grant_valid_o)
//   grant_valid_o : at least one port is eligible
module rr_sp_grant
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS = 6
) (
    input  logic [NUM_PORTS-1:0]        elig_i,
    input  logic [clog2(NUM_PORTS)-1:0] last_grant_i,
    input  logic                        mode_i,
    output logic [clog2(NUM_PORTS)-1:0] grant_o,
    output logic                        grant_valid_o
);

    localparam int PW = clog2(NUM_PORTS);
    localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);
    localparam logic [PW-1:0] PW_ONE    = 1;

    logic          rr_found;
    logic [PW-1:0] rr_idx;
    logic          sp_found;
    logic [PW-1:0] sp_idx;
    logic [PW-1:0] scan_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        sp_found = 1'b0;
        sp_idx   = '0;
        // Wrap is an explicit compare: NUM_PORTS is rarely a power of two.
        scan_idx = (last_grant_i == LAST_PORT) ? '0 : last_grant_i + PW_ONE;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!rr_found && elig_i[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_PORT) ? '0 : scan_idx + PW_ONE;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!sp_found && elig_i[i]) begin
                sp_found = 1'b1;
                sp_idx   = PW'(i);
            end
        end
    end

    assign grant_o       = (mode_i == ARB_SP) ? sp_idx : rr_idx;
    assign grant_valid_o = |elig_i;

endmodule

// File: rtl/input_arbiter_nport.sv
// N-port AXI-Stream input arbiter. Each slave port feeds a fall-through FIFO;
// whole packets are forwarded one at a time to the single master stream.
//   axis_aclk, axis_resetn : clock, synchronous active-low reset (flushes FIFOs)
//   s_axis_*               : per-port slave streams, port p at slice p
//   m_axis_*               : merged master stream
//   arb_mode               : ARB_RR round-robin, ARB_SP strict priority
//   port_enable            : ports allowed to win a new grant
//   cur_port               : port of the packet most recently started
//   pkt_fwd, pkt_fwd_port  : registered pulse (one-hot port) for the cycle
//                            after each packet's first-beat handshake
module input_arbiter_nport
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS            = 6,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAX_PKT_BYTES        = 2000
) (
    input  logic                                       axis_aclk,
    input  logic                                       axis_resetn,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_PORTS-1:0]                       s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                       s_axis_tready,
    input  logic [NUM_PORTS-1:0]                       s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,
    input  logic                                       arb_mode,
    input  logic [NUM_PORTS-1:0]                       port_enable,
    output logic [clog2(NUM_PORTS)-1:0]                cur_port,
    output logic                                       pkt_fwd,
    output logic [NUM_PORTS-1:0]                       pkt_fwd_port
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int FW = 1 + UW + KW + DW;
    localparam int PW = clog2(NUM_PORTS);
    localparam int FIFO_DEPTH_BITS = clog2(MAX_PKT_BYTES / KW);
    localparam logic [PW-1:0]        LAST_PORT = PW'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0] PORT_ONE  = 1;

    logic [FW-1:0]        fifo_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_nearly_full;
    logic [NUM_PORTS-1:0] fifo_wr_en;
    logic [NUM_PORTS-1:0] fifo_rd_en;
    logic [NUM_PORTS-1:0] elig;

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        last_grant_q, last_grant_d;
    logic [PW-1:0]        cur_port_q, cur_port_d;
    logic                 pkt_fwd_q, pkt_fwd_d;
    logic [NUM_PORTS-1:0] pkt_fwd_port_q, pkt_fwd_port_d;

    logic [PW-1:0] grant;
    logic          grant_valid;
    logic [PW-1:0] sel;
    logic          m_valid;
    logic          m_handshake;
    logic [FW-1:0] head;
    logic          head_last;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign fifo_wr_en[gi] = s_axis_tvalid[gi] & s_axis_tready[gi];
        assign fifo_rd_en[gi] = m_handshake & (sel == PW'(gi));

        fallthrough_small_fifo #(
            .WIDTH      (FW),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_i         (axis_aclk),
            .rst_ni        (axis_resetn),
            .din_i         ({s_axis_tlast[gi], s_axis_tuser[gi*UW +: UW],
                             s_axis_tkeep[gi*KW +: KW], s_axis_tdata[gi*DW +: DW]}),
            .wr_en_i       (fifo_wr_en[gi]),
            .rd_en_i       (fifo_rd_en[gi]),
            .dout_o        (fifo_dout[gi]),
            .empty_o       (fifo_empty[gi]),
            .nearly_full_o (fifo_nearly_full[gi])
        );
    end

    assign s_axis_tready = ~fifo_nearly_full;
    assign elig          = ~fifo_empty & port_enable;

    rr_sp_grant #(
        .NUM_PORTS (NUM_PORTS)
    ) u_grant (
        .elig_i        (elig),
        .last_grant_i  (last_grant_q),
        .mode_i        (arb_mode),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    // The grant only steers the output between packets; inside a packet the
    // source is pinned to cur_port so enable/mode changes cannot split it.
    always_comb begin
        sel     = cur_port_q;
        m_valid = 1'b0;
        if (state_q == IDLE) begin
            sel     = grant;
            m_valid = grant_valid;
        end else begin
            // An empty source mid-packet stalls the stream rather than ending it.
            m_valid = ~fifo_empty[cur_port_q];
        end
    end

    assign m_handshake = m_valid & m_axis_tready;
    assign head        = fifo_dout[sel];
    assign head_last   = head[FW-1];

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        cur_port_d     = cur_port_q;
        pkt_fwd_d      = 1'b0;
        pkt_fwd_port_d = '0;
        case (state_q)
            IDLE: begin
                if (m_handshake) begin
                    cur_port_d     = grant;
                    pkt_fwd_d      = 1'b1;
                    pkt_fwd_port_d = PORT_ONE << grant;
                    if (head_last) begin
                        last_grant_d = grant;
                    end else begin
                        state_d = WR_PKT;
                    end
                end
            end
            WR_PKT: begin
                if (m_handshake && head_last) begin
                    state_d      = IDLE;
                    last_grant_d = cur_port_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q        <= IDLE;
            last_grant_q   <= LAST_PORT;
            cur_port_q     <= '0;
            pkt_fwd_q      <= 1'b0;
            pkt_fwd_port_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            cur_port_q     <= cur_port_d;
            pkt_fwd_q      <= pkt_fwd_d;
            pkt_fwd_port_q <= pkt_fwd_port_d;
        end
    end

    assign m_axis_tdata  = head[DW-1:0];
    assign m_axis_tkeep  = head[DW +: KW];
    assign m_axis_tuser  = head[DW+KW +: UW];
    assign m_axis_tlast  = head_last;
    assign m_axis_tvalid = m_valid;
    assign cur_port      = cur_port_q;
    assign pkt_fwd       = pkt_fwd_q;
    assign pkt_fwd_port  = pkt_fwd_port_q;

endmodule

// File: tb/tb_input_arbiter_nport.sv
module tb_input_arbiter_nport;

    localparam int NP = 6;
    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int UW = 16;
    localparam int PW = 3;
    localparam int BW = 1 + UW + KW + DW;

    logic              clk = 1'b0;
    logic              resetn;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP*KW-1:0]  s_axis_tkeep;
    logic [NP*UW-1:0]  s_axis_tuser;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP-1:0]     s_axis_tready;
    logic [NP-1:0]     s_axis_tlast;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              arb_mode;
    logic [NP-1:0]     port_enable;
    logic [PW-1:0]     cur_port;
    logic              pkt_fwd;
    logic [NP-1:0]     pkt_fwd_port;

    logic rdy_fixed = 1'b0;
    logic rand_rdy  = 1'b0;
    logic rand_bit  = 1'b0;

    // Scoreboard: per-port beats pushed as they are written, expected packet
    // source order pushed by each test.
    logic [BW-1:0] beatq [NP][$];
    int            order_q [$];
    bit            in_pkt = 1'b0;
    int            src = -1;
    bit            exp_fwd_pending = 1'b0;
    int            exp_fwd_port = 0;
    int            fwd_seen = 0;
    int            out_beats = 0;
    int            n_checks = 0;
    int            n_err = 0;
    logic [BW-1:0] act_beat;
    logic [BW-1:0] exp_beat;

    always #5 clk = ~clk;
    always @(posedge clk) rand_bit <= 1'($urandom_range(0, 1));
    assign m_axis_tready = rand_rdy ? rand_bit : rdy_fixed;

    input_arbiter_nport #(
        .NUM_PORTS            (NP),
        .C_M_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_M_AXIS_TUSER_WIDTH (UW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .MAX_PKT_BYTES        (256)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .arb_mode      (arb_mode),
        .port_enable   (port_enable),
        .cur_port      (cur_port),
        .pkt_fwd       (pkt_fwd),
        .pkt_fwd_port  (pkt_fwd_port)
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit sb_all_empty();
        for (int p = 0; p < NP; p++) begin
            if (beatq[p].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_sb();
        order_q.delete();
        for (int p = 0; p < NP; p++) beatq[p].delete();
        in_pkt = 1'b0;
        src = -1;
        exp_fwd_pending = 1'b0;
        fwd_seen = 0;
        out_beats = 0;
    endtask

    // Monitor, sampled mid-cycle: outputs are checked before this cycle's
    // input beats are recorded, since those are not yet in the FIFOs.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (exp_fwd_pending) begin
                check("pkt_fwd", 128'(pkt_fwd), 128'(1));
                check("pkt_fwd_port", 128'(pkt_fwd_port), 128'(1 << exp_fwd_port));
                check("cur_port", 128'(cur_port), 128'(exp_fwd_port));
                exp_fwd_pending = 1'b0;
            end else begin
                check("pkt_fwd_quiet", 128'(pkt_fwd), 128'(0));
            end
            if (pkt_fwd) fwd_seen++;

            if (!in_pkt && sb_all_empty()) check("idle_tvalid", 128'(m_axis_tvalid), 128'(0));
            if (in_pkt && src >= 0 && beatq[src].size() == 0)
                check("underrun_tvalid", 128'(m_axis_tvalid), 128'(0));

            if (m_axis_tvalid && m_axis_tready) begin
                act_beat = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
                if (!in_pkt) begin
                    check("pkt_expected", 128'(order_q.size() > 0), 128'(1));
                    if (order_q.size() > 0) begin
                        src = order_q.pop_front();
                        exp_fwd_pending = 1'b1;
                        exp_fwd_port = src;
                    end else begin
                        src = -1;
                    end
                end
                if (src >= 0) begin
                    check("beat_expected", 128'(beatq[src].size() > 0), 128'(1));
                    if (beatq[src].size() > 0) begin
                        exp_beat = beatq[src].pop_front();
                        check("beat", 128'(act_beat), 128'(exp_beat));
                        $display("beat port=%0d data=%h last=%0d", src, m_axis_tdata, m_axis_tlast);
                    end
                end
                out_beats++;
                in_pkt = !m_axis_tlast;
            end

            for (int p = 0; p < NP; p++) begin
                if (s_axis_tvalid[p] && s_axis_tready[p])
                    beatq[p].push_back({s_axis_tlast[p], s_axis_tuser[p*UW +: UW],
                                        s_axis_tkeep[p*KW +: KW], s_axis_tdata[p*DW +: DW]});
            end
        end
    end

    task automatic wait_ready(input int p);
        int n = 0;
        forever begin
            @(negedge clk);
            if (s_axis_tready[p]) break;
            n++;
            if (n > 200) begin
                check("s_tready_timeout", 128'(s_axis_tready[p]), 128'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int p, input int nb, input int seq, input int pause_at, input int pause_len);
        for (int b = 0; b < nb; b++) begin
            if (b == pause_at) begin
                s_axis_tvalid[p] = 1'b0;
                repeat (pause_len) @(posedge clk);
                #1;
            end
            s_axis_tdata[p*DW +: DW] = {8'(p), 8'(seq), 8'(b), 8'($urandom), 32'($urandom)};
            s_axis_tkeep[p*KW +: KW] = 8'($urandom) | 8'h01;
            s_axis_tuser[p*UW +: UW] = {8'(p), 8'(b)};
            s_axis_tlast[p] = (b == nb - 1);
            s_axis_tvalid[p] = 1'b1;
            wait_ready(p);
        end
        s_axis_tvalid[p] = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((order_q.size() != 0 || in_pkt) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drain"}, 128'(n < 3000), 128'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (out_beats < k && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("wait_beats", 128'(out_beats >= k), 128'(1));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rdy_fixed = 1'b0;
        rand_rdy = 1'b0;
        clear_sb();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst_cur_port", 128'(cur_port), 128'(0));
        check("rst_pkt_fwd", 128'(pkt_fwd), 128'(0));
        check("rst_pkt_fwd_port", 128'(pkt_fwd_port), 128'(0));
        check("rst_s_tready", 128'(s_axis_tready), 128'({NP{1'b1}}));
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tuser = '0;
        s_axis_tvalid = '0;
        s_axis_tlast = '0;
        arb_mode = 1'b0;
        port_enable = '1;

        // RR fairness: ports 0,2,5 with three 4-beat packets each.
        do_reset();
        arb_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_pkt(0, 4, k, -1, 0);
            send_pkt(2, 4, k, -1, 0);
            send_pkt(5, 4, k, -1, 0);
        end
        for (int k = 0; k < 3; k++) begin
            order_q.push_back(0);
            order_q.push_back(2);
            order_q.push_back(5);
        end
        rdy_fixed = 1'b1;
        wait_drain("rr");
        check("rr_fwd_count", 128'(fwd_seen), 128'(9));

        // Strict priority: port 1 arrives during port 4's first packet.
        do_reset();
        arb_mode = 1'b1;
        send_pkt(4, 10, 0, -1, 0);
        send_pkt(4, 10, 1, -1, 0);
        order_q.push_back(4);
        order_q.push_back(1);
        order_q.push_back(4);
        rdy_fixed = 1'b1;
        wait_beats(3);
        #1;
        send_pkt(1, 3, 0, -1, 0);
        wait_drain("sp");
        check("sp_fwd_count", 128'(fwd_seen), 128'(3));

        // Enable mask: port 0 held back until its enable bit is set.
        do_reset();
        arb_mode = 1'b0;
        port_enable = 6'b111110;
        send_pkt(0, 2, 0, -1, 0);
        send_pkt(3, 2, 0, -1, 0);
        order_q.push_back(3);
        rdy_fixed = 1'b1;
        wait_drain("mask");
        repeat (10) @(posedge clk);
        #1;
        check("mask_fwd_count", 128'(fwd_seen), 128'(1));
        order_q.push_back(0);
        port_enable = '1;
        wait_drain("mask_en");
        check("mask_en_fwd_count", 128'(fwd_seen), 128'(2));

        // Random backpressure with a writer pause (underrun) on port 3.
        do_reset();
        arb_mode = 1'b0;
        rand_rdy = 1'b1;
        order_q.push_back(3);
        order_q.push_back(3);
        send_pkt(3, 6, 0, 3, 8);
        send_pkt(3, 4, 1, -1, 0);
        wait_drain("bp");
        check("bp_beats", 128'(out_beats), 128'(10));
        rand_rdy = 1'b0;

        // Single-beat packets alternate between ports 0 and 1.
        do_reset();
        arb_mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_pkt(0, 1, k, -1, 0);
            send_pkt(1, 1, k, -1, 0);
            order_q.push_back(0);
            order_q.push_back(1);
        end
        rdy_fixed = 1'b1;
        wait_drain("single");
        check("single_fwd_count", 128'(fwd_seen), 128'(10));

        // Reset on beat 3 of an 8-beat packet from port 2.
        do_reset();
        send_pkt(2, 8, 0, -1, 0);
        order_q.push_back(2);
        rdy_fixed = 1'b1;
        wait_beats(3);
        #1;
        resetn = 1'b0;
        clear_sb();
        @(posedge clk);
        @(negedge clk);
        check("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
        check("midrst_pkt_fwd", 128'(pkt_fwd), 128'(0));
        check("midrst_cur_port", 128'(cur_port), 128'(0));
        check("midrst_s_tready", 128'(s_axis_tready), 128'({NP{1'b1}}));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        order_q.push_back(2);
        send_pkt(2, 8, 1, -1, 0);
        wait_drain("midrst");
        check("midrst_beats", 128'(out_beats), 128'(8));
        check("midrst_fwd_count", 128'(fwd_seen), 128'(1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
